// File: rtl/camera_pkg.sv
`default_nettype none
// ============================================================================
// Module   : camera_pkg
// Brief    : Shared widths, pixel type and dummy-generator timing constants.
// Revision : 1.0 - initial release
// ============================================================================
package camera_pkg;

    localparam int PIXEL_W     = 16;
    localparam int BYTE_W      = 8;
    localparam int DUMMY_CNT_W = 16;

    // Dummy generator frame timing, in pixel-clock cycles
    localparam int VS_CYCLES = 1;
    localparam int H_GAP     = 1;
    localparam int V_IDLE    = 5;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // First byte of the pair lands in the upper half of the pixel
    function automatic rgb565_t pack_pixel(input logic [BYTE_W-1:0] hi,
                                           input logic [BYTE_W-1:0] lo);
        return rgb565_t'({hi, lo});
    endfunction

endpackage
`default_nettype wire

// File: rtl/camera_capture_top_dummy_camera.sv
`default_nettype none
// ============================================================================
// Module   : dummy_camera
// Brief    : Free-running VSYNC/HREF/byte pattern for bring-up without a sensor.
// Revision : 1.0 - initial release
// ============================================================================
module dummy_camera
    import camera_pkg::*;
#(
    parameter int H_BYTES = 1280,
    parameter int V_LINES = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              vsync,
    output logic              href,
    output logic [BYTE_W-1:0] data
);

    localparam logic [1:0] S_VS   = 2'd0;
    localparam logic [1:0] S_LINE = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_IDLE = 2'd3;

    localparam logic [DUMMY_CNT_W-1:0] c_vs_last   = DUMMY_CNT_W'(VS_CYCLES - 1);
    localparam logic [DUMMY_CNT_W-1:0] c_h_last    = DUMMY_CNT_W'(H_BYTES - 1);
    localparam logic [DUMMY_CNT_W-1:0] c_gap_last  = DUMMY_CNT_W'(H_GAP - 1);
    localparam logic [DUMMY_CNT_W-1:0] c_v_last    = DUMMY_CNT_W'(V_LINES - 1);
    localparam logic [DUMMY_CNT_W-1:0] c_idle_last = DUMMY_CNT_W'(V_IDLE - 1);

    logic [1:0]             r_state;
    logic [DUMMY_CNT_W-1:0] r_cnt;
    logic [DUMMY_CNT_W-1:0] r_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_VS;
            r_cnt   <= '0;
            r_line  <= '0;
        end else begin
            case (r_state)
                S_VS: begin
                    if (r_cnt == c_vs_last) begin
                        r_state <= S_LINE;
                        r_cnt   <= '0;
                        r_line  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LINE: begin
                    if (r_cnt == c_h_last) begin
                        r_state <= S_GAP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == c_gap_last) begin
                        r_cnt <= '0;
                        if (r_line == c_v_last) begin
                            r_state <= S_IDLE;
                            r_line  <= '0;
                        end else begin
                            r_state <= S_LINE;
                            r_line  <= r_line + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (r_cnt == c_idle_last) begin
                        r_state <= S_VS;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_VS;
                    r_cnt   <= '0;
                    r_line  <= '0;
                end
            endcase
        end
    end

    // vsync spans the start pulse, all lines and the final line gap
    assign vsync = (r_state != S_IDLE);
    assign href  = (r_state == S_LINE);
    assign data  = r_cnt[BYTE_W-1:0];

endmodule
`default_nettype wire

// File: rtl/camera_capture_top.sv
`default_nettype none
// ============================================================================
// Module   : camera_capture_top
// Brief    : Registers an 8-bit camera bus and pairs bytes into RGB565 VFB writes.
// Revision : 1.0 - initial release
// ============================================================================
module camera_capture_top
    import camera_pkg::*;
#(
    parameter bit DUMMY_MODE    = 1'b0,
    parameter int DUMMY_H_BYTES = 1280,
    parameter int DUMMY_V_LINES = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               xclk,
    input  logic               vsync,
    input  logic               href,
    input  logic [BYTE_W-1:0]  data_i,
    output logic               vfb_clk,
    output logic               vfb_vs_n,
    output logic               vfb_de,
    output logic [PIXEL_W-1:0] vfb_data
);

    logic              w_src_vs;
    logic              w_src_hr;
    logic [BYTE_W-1:0] w_src_d;

    generate
        if (DUMMY_MODE) begin : g_dummy
            dummy_camera #(
                .H_BYTES (DUMMY_H_BYTES),
                .V_LINES (DUMMY_V_LINES)
            ) u_dummy_camera (
                .clk   (clk),
                .rst_n (rst_n),
                .vsync (w_src_vs),
                .href  (w_src_hr),
                .data  (w_src_d)
            );
        end else begin : g_sensor
            assign w_src_vs = vsync;
            assign w_src_hr = href;
            assign w_src_d  = data_i;
        end
    endgenerate

    // xclk is sensor-side only; pins are also idle in dummy mode
    logic w_unused;
    assign w_unused = ^{xclk, vsync, href, data_i};

    logic              vs_r;
    logic              hr_r;
    logic [BYTE_W-1:0] d_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_r <= 1'b0;
            hr_r <= 1'b0;
            d_r  <= '0;
        end else begin
            vs_r <= w_src_vs;
            hr_r <= w_src_hr;
            d_r  <= w_src_d;
        end
    end

    logic              r_phase;
    logic [BYTE_W-1:0] r_hi;
    logic              r_vs_n;
    logic              r_de;
    rgb565_t           r_data;

    // Only href resets pairing; an unpaired trailing byte is simply dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
            r_hi    <= '0;
            r_vs_n  <= 1'b1;
            r_de    <= 1'b0;
            r_data  <= '0;
        end else begin
            r_vs_n <= ~vs_r;
            if (!hr_r) begin
                r_phase <= 1'b0;
                r_de    <= 1'b0;
            end else if (!r_phase) begin
                r_hi    <= d_r;
                r_phase <= 1'b1;
                r_de    <= 1'b0;
            end else begin
                r_data  <= pack_pixel(r_hi, d_r);
                r_de    <= 1'b1;
                r_phase <= 1'b0;
            end
        end
    end

    assign vfb_clk  = clk;
    assign vfb_vs_n = r_vs_n;
    assign vfb_de   = r_de;
    assign vfb_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_camera_capture_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_camera_capture_top
// Brief    : Directed scoreboard bench for sensor and dummy capture modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_camera_capture_top;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        xclk   = 1'b0;
    logic        vsync  = 1'b0;
    logic        href   = 1'b0;
    logic [7:0]  data_i = 8'h00;
    logic        vfb_clk;
    logic        vfb_vs_n;
    logic        vfb_de;
    logic [15:0] vfb_data;

    logic        d_rst_n = 1'b0;
    logic        rnd_vs  = 1'b0;
    logic        rnd_hr  = 1'b0;
    logic [7:0]  rnd_d   = 8'h00;
    logic        d_vfb_clk;
    logic        d_vfb_vs_n;
    logic        d_vfb_de;
    logic [15:0] d_vfb_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] pix;
        int          at;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          pushed = 0;
    int          popped = 0;
    logic        prev_de = 1'b0;
    logic [15:0] d_pix[$];
    int          d_at[$];
    logic [15:0] pat [4];

    camera_capture_top u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .xclk     (xclk),
        .vsync    (vsync),
        .href     (href),
        .data_i   (data_i),
        .vfb_clk  (vfb_clk),
        .vfb_vs_n (vfb_vs_n),
        .vfb_de   (vfb_de),
        .vfb_data (vfb_data)
    );

    camera_capture_top #(
        .DUMMY_MODE    (1'b1),
        .DUMMY_H_BYTES (4),
        .DUMMY_V_LINES (2)
    ) u_dut_dummy (
        .clk      (clk),
        .rst_n    (d_rst_n),
        .xclk     (xclk),
        .vsync    (rnd_vs),
        .href     (rnd_hr),
        .data_i   (rnd_d),
        .vfb_clk  (d_vfb_clk),
        .vfb_vs_n (d_vfb_vs_n),
        .vfb_de   (d_vfb_de),
        .vfb_data (d_vfb_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel monitor for the sensor-mode instance
    always @(negedge clk) begin
        if (vfb_de) begin
            total++;
            assert (prev_de === 1'b0) else begin
                bad++;
                $error("FAIL de_back_to_back observed=%0b expected=0", prev_de);
            end
            total++;
            assert (vfb_vs_n === 1'b0) else begin
                bad++;
                $error("FAIL vs_n_during_pixel observed=%0b expected=0", vfb_vs_n);
            end
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_pixel observed=%h expected=none", vfb_data);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                popped++;
                total++;
                assert (vfb_data === mon_e.pix) else begin
                    bad++;
                    $error("FAIL pixel_data observed=%h expected=%h", vfb_data, mon_e.pix);
                end
                total++;
                assert (cyc === mon_e.at) else begin
                    bad++;
                    $error("FAIL pixel_cycle observed=%0d expected=%0d", cyc, mon_e.at);
                end
            end
        end
        prev_de = vfb_de;
    end

    always @(negedge clk) begin
        if (d_rst_n && d_vfb_de && d_pix.size() < 16) begin
            d_pix.push_back(d_vfb_data);
            d_at.push_back(cyc);
        end
    end

    // Noise on the dummy instance's sensor pins
    initial begin
        forever begin
            @(negedge clk);
            {rnd_vs, rnd_hr, rnd_d} = 10'($urandom);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic vs, input logic hr, input logic [7:0] d);
        @(posedge clk);
        #1;
        vsync  = vs;
        href   = hr;
        data_i = d;
    endtask

    task automatic push_pix(input logic [15:0] p);
        sb.push_back('{pix: p, at: cyc + 2});
        pushed++;
    endtask

    task automatic send_line(input logic [7:0] base, input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i);
            step(1'b1, 1'b1, b);
            if (i % 2 == 1) push_pix({b - 8'd1, b});
        end
        step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        pat[0] = 16'h0001;
        pat[1] = 16'h0203;
        pat[2] = 16'h0001;
        pat[3] = 16'h0203;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_vs_n", 32'(vfb_vs_n), 32'd1);
        check("reset_de", 32'(vfb_de), 32'd0);
        check("reset_data", 32'(vfb_data), 32'h0000);
        check("reset_dummy_de", 32'(d_vfb_de), 32'd0);
        check("vfb_clk_high", 32'(vfb_clk), 32'd1);
        @(negedge clk);
        #1;
        check("vfb_clk_low", 32'(vfb_clk), 32'd0);
        rst_n   = 1'b1;
        d_rst_n = 1'b1;

        // Five identical frames, each restarting at 0001
        for (int f = 0; f < 5; f++) begin
            step(1'b1, 1'b0, 8'h00);
            send_line(8'h00, 10);
            idle(5);
            check("vs_n_between_frames", 32'(vfb_vs_n), 32'd1);
        end

        // Odd line then a fresh even line
        step(1'b1, 1'b0, 8'h00);
        send_line(8'h00, 7);
        send_line(8'h20, 4);
        idle(5);

        // Reset mid-line
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h10);
        step(1'b1, 1'b1, 8'h11);
        push_pix(16'h1011);
        step(1'b1, 1'b1, 8'h12);
        step(1'b1, 1'b1, 8'h13);
        @(negedge clk);
        #1;
        check("pre_reset_de", 32'(vfb_de), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_de", 32'(vfb_de), 32'd0);
        check("async_reset_data", 32'(vfb_data), 32'h0000);
        check("async_reset_vs_n", 32'(vfb_vs_n), 32'd1);
        vsync  = 1'b0;
        href   = 1'b0;
        data_i = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h00);
        send_line(8'hA0, 4);
        idle(5);

        // Drain with a bounded wait
        for (int i = 0; i < 20 && sb.size() != 0; i++) step(1'b0, 1'b0, 8'h00);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("pixel_count", 32'(popped), 32'(pushed));

        // Dummy-generator instance: pattern and frame period
        check("dummy_pixels_seen", 32'(d_pix.size() >= 8), 32'd1);
        if (d_pix.size() >= 8) begin
            for (int i = 0; i < 8; i++)
                check($sformatf("dummy_pix%0d", i), 32'(d_pix[i]), 32'(pat[i % 4]));
            check("dummy_pair_spacing", 32'(d_at[1] - d_at[0]), 32'd2);
            for (int i = 4; i < 8; i++)
                check($sformatf("dummy_period%0d", i), 32'(d_at[i] - d_at[i-4]), 32'd16);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
